// File: rtl/inst_mem_loader.sv
// Stream-to-InstROM writer: sequential writes from a captured base address, then a one-cycle start pulse.
// Optional feature INST_MEM_LOADER_CKSUM_EN: the in_last beat is an XOR checksum of the session's words.
module inst_mem_loader #(
    parameter int ADDR_W = 11,
    parameter int INST_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              busy,
    output logic              start,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] wdata_q, wdata_d;
    logic              ready_q, busy_q, start_q;
    logic              accept_s;
`ifdef INST_MEM_LOADER_CKSUM_EN
    logic [INST_W-1:0] xor_q, xor_d;
`endif

    // Running checksum update: XOR fold of one more word
    function automatic logic [INST_W-1:0] cksum_next(input logic [INST_W-1:0] acc,
                                                     input logic [INST_W-1:0] word);
        return acc ^ word;
    endfunction

    // in_ready is a registered decode of the LOAD state, so accept needs no state compare
    assign accept_s = ready_q & in_valid;

    // Next-state, write-pointer and write-port logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef INST_MEM_LOADER_CKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (load_req) begin
                    state_d = LOAD;
                    ptr_d   = base_addr;
                    cnt_d   = {(ADDR_W+1){1'b0}};
                    err_d   = 1'b0;
`ifdef INST_MEM_LOADER_CKSUM_EN
                    xor_d   = {INST_W{1'b0}};
`endif
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
`ifdef INST_MEM_LOADER_CKSUM_EN
                if (accept_s && in_last) begin
                    // checksum beat: compared, never written or counted
                    if (in_data == xor_q) begin
                        state_d = START;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end else if (accept_s) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    cnt_d   = cnt_q + CNT_ONE;
                    xor_d   = cksum_next(xor_q, in_data);
                    if (ptr_q == PTR_MAX) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end else begin
                    state_d = LOAD;
                end
`else
                if (accept_s) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (in_last) begin
                        state_d = START;
                    end else if (ptr_q == PTR_MAX) begin
                        // pointer pinned at top of memory; session aborts
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end else begin
                    state_d = LOAD;
                end
`endif
            end
            START: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= {ADDR_W{1'b0}};
            cnt_q   <= {(ADDR_W+1){1'b0}};
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {INST_W{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
`ifdef INST_MEM_LOADER_CKSUM_EN
            xor_q   <= {INST_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= (state_d == LOAD);
            busy_q  <= (state_d == LOAD) || (state_d == START);
            start_q <= (state_d == START);
`ifdef INST_MEM_LOADER_CKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign in_ready   = ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign start      = start_q;
    assign word_count = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes queued at acceptance, popped by a monitor.
`timescale 1ns/1ps
module tb_inst_mem_loader;

    localparam int ADDR_W = 11;
    localparam int INST_W = 9;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              load_req = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic [INST_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready, mem_we, busy, start, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_wdata;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [ADDR_W+INST_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_ptr;
    logic [ADDR_W:0]   exp_cnt;
    bit                acc;

    inst_mem_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk(clk), .reset_n(reset_n), .load_req(load_req), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .start(start), .word_count(word_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard; start only once all writes are out
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    chk("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
                end
            end
            if (start) begin
                start_cnt++;
                chk("start_after_writes", exp_q.size(), 32'd0);
            end
        end
    end

    task automatic begin_session(input logic [ADDR_W-1:0] base);
        load_req = 1'b1; base_addr = base;
        @(posedge clk); #1;
        load_req = 1'b0;
        exp_ptr = base; exp_cnt = '0; start_cnt = 0;
    endtask

    // Present one word (after gap idle cycles); acc reports whether it was accepted within budget
    task automatic offer(input logic [INST_W-1:0] d, input logic last, input logic written,
                         input int gap, input int budget, output bit accepted);
        accepted = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d; in_last = last;
        for (int k = 0; k < budget; k++) begin
            if (in_ready) begin
                accepted = 1'b1;
                if (written) begin
                    exp_q.push_back({exp_ptr, d});
                    exp_cnt = exp_cnt + 1'b1;
                    if (exp_ptr != {ADDR_W{1'b1}}) exp_ptr = exp_ptr + 1'b1;
                end
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic finish_check(input string tag, input int exp_start, input logic exp_err);
        repeat (3) @(posedge clk); #1;
        chk({tag, "_start_cnt"}, start_cnt, exp_start);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_word_count"}, word_count, exp_cnt);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic send_ok(input logic [INST_W-1:0] d, input logic last, input int gap);
        offer(d, last, 1'b1, gap, 8, acc);
        chk("accepted", acc, 1'b1);
    endtask

    initial begin
        #12 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs", {in_ready, mem_we, start, busy, err, mem_addr, mem_wdata, word_count},
            32'd0);

        // 1: back-to-back stream from address 0
        begin_session(11'd0);
        chk("t1_busy", busy, 1'b1);
        send_ok(9'b000000001, 1'b0, 0);
        send_ok(9'b000000010, 1'b0, 0);
        send_ok(9'b000000011, 1'b1, 0);
        finish_check("t1", 1, 1'b0);
        chk("t1_count3", word_count, 12'd3);
        offer(9'h1FF, 1'b1, 1'b0, 0, 3, acc);
        chk("done_ignores_valid", acc, 1'b0);

        // 2: two idle cycles between words
        begin_session(11'd0);
        send_ok(9'b000000001, 1'b0, 2);
        send_ok(9'b000000010, 1'b0, 2);
        send_ok(9'b000000011, 1'b1, 2);
        finish_check("t2", 1, 1'b0);

        // 3: overflow at the top of memory
        begin_session(11'd2046);
        send_ok(9'h011, 1'b0, 0);
        send_ok(9'h022, 1'b0, 0);
        offer(9'h033, 1'b1, 1'b0, 0, 4, acc);
        chk("t3_third_refused", acc, 1'b0);
        finish_check("t3", 0, 1'b1);
        chk("t3_count2", word_count, 12'd2);

        // 4: asynchronous reset after the 2nd of 5 words
        begin_session(11'd100);
        send_ok(9'h101, 1'b0, 0);
        send_ok(9'h102, 1'b0, 0);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #0.5;
        chk("t4_async_clear", {in_ready, mem_we, start, busy, err, mem_addr, mem_wdata, word_count},
            32'd0);
        #0.5 reset_n = 1'b1;
        offer(9'h103, 1'b0, 1'b0, 0, 3, acc);
        chk("t4_idle_refuses", acc, 1'b0);
        begin_session(11'd7);
        send_ok(9'h0AA, 1'b0, 0);
        send_ok(9'h155, 1'b1, 0);
        finish_check("t4", 1, 1'b0);

`ifdef INST_MEM_LOADER_CKSUM_EN
        // 5: checksum match then mismatch
        begin_session(11'd0);
        send_ok(9'h0A5, 1'b0, 0);
        send_ok(9'h03C, 1'b0, 0);
        offer(9'h099, 1'b1, 1'b0, 0, 8, acc);
        chk("t5_cksum_acc", acc, 1'b1);
        finish_check("t5a", 1, 1'b0);
        begin_session(11'd0);
        send_ok(9'h0A5, 1'b0, 0);
        send_ok(9'h03C, 1'b0, 0);
        offer(9'h098, 1'b1, 1'b0, 0, 8, acc);
        chk("t5_bad_acc", acc, 1'b1);
        finish_check("t5b", 0, 1'b1);
`endif

        // 6: load_req mid-session is ignored; err from t3 was already cleared by restarts
        begin_session(11'd300);
        send_ok(9'h0F0, 1'b0, 0);
        load_req = 1'b1; base_addr = 11'd5;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk("t6_count_kept", word_count, 12'd1);
        send_ok(9'h00F, 1'b0, 0);
`ifdef INST_MEM_LOADER_CKSUM_EN
        offer(9'h0FF, 1'b1, 1'b0, 0, 8, acc);
        chk("t6_cksum_acc", acc, 1'b1);
`else
        send_ok(9'h0FF, 1'b1, 0);
`endif
        finish_check("t6", 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
